// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage
// (req0) and the branch/PC unit (req1); also holds the sticky zero/neg flags.
module alu_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter logic [2:0]  NOP_OP = 3'b011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_req_valid,
    output logic [1:0]       out_req_ready,
    input  logic [WIDTH-1:0] in_req0_a,
    input  logic [WIDTH-1:0] in_req0_b,
    input  logic [2:0]       in_req0_op,
    input  logic [WIDTH-1:0] in_req1_a,
    input  logic [WIDTH-1:0] in_req1_b,
    input  logic [2:0]       in_req1_op,
    output logic [WIDTH-1:0] out_alu_a,
    output logic [WIDTH-1:0] out_alu_b,
    output logic [2:0]       out_alu_op,
    input  logic [WIDTH-1:0] in_alu_result,
    input  logic             in_alu_zero,
    input  logic             in_alu_neg,
    output logic             out_resp_valid,
    input  logic             in_resp_ready,
    output logic             out_resp_id,
    output logic [WIDTH-1:0] out_resp_result,
    output logic             out_resp_zero,
    output logic             out_resp_neg,
    output logic             out_flag_zero,
    output logic             out_flag_neg,
    output logic             out_busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             nop_pending;
    logic [1:0]       grant;
    logic             accept;
    logic             gnt_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    function automatic logic is_legal(input logic [2:0] op);
        case (op)
            3'b100, 3'b010, 3'b001, 3'b000, 3'b111: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Pointer requester wins when valid; otherwise the other one may take the slot.
    always_comb begin
        grant = '0;
        if (state == IDLE && !rst) begin
            if (in_req_valid[ptr]) begin
                grant[ptr] = 1'b1;
            end else if (in_req_valid[~ptr]) begin
                grant[~ptr] = 1'b1;
            end
        end
    end

    assign accept = |grant;
    assign gnt_id = grant[1];

    always_comb begin
        sel_a  = in_req0_a;
        sel_b  = in_req0_b;
        sel_op = in_req0_op;
        if (gnt_id) begin
            sel_a  = in_req1_a;
            sel_b  = in_req1_b;
            sel_op = in_req1_op;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (in_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr             <= 1'b0;
            nop_pending     <= 1'b0;
            out_alu_a       <= '0;
            out_alu_b       <= '0;
            out_alu_op      <= NOP_OP;
            out_resp_id     <= 1'b0;
            out_resp_result <= '0;
            out_resp_zero   <= 1'b0;
            out_resp_neg    <= 1'b0;
            out_flag_zero   <= 1'b0;
            out_flag_neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_alu_a   <= sel_a;
                        out_alu_b   <= sel_b;
                        out_alu_op  <= is_legal(sel_op) ? sel_op : NOP_OP;
                        nop_pending <= !is_legal(sel_op);
                        out_resp_id <= gnt_id;
                        ptr         <= ~gnt_id;
                    end
                end
                EXEC: begin
                    // NOP-class ops report the sticky flags and never disturb them.
                    if (nop_pending) begin
                        out_resp_result <= '0;
                        out_resp_zero   <= out_flag_zero;
                        out_resp_neg    <= out_flag_neg;
                    end else begin
                        out_resp_result <= in_alu_result;
                        out_resp_zero   <= in_alu_zero;
                        out_resp_neg    <= in_alu_neg;
                        out_flag_zero   <= in_alu_zero;
                        out_flag_neg    <= in_alu_neg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_req_ready  = grant;
    assign out_resp_valid = (state == RESP);
    assign out_busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       in_req_valid = '0;
    logic [1:0]       out_req_ready;
    logic [WIDTH-1:0] in_req0_a = '0, in_req0_b = '0, in_req1_a = '0, in_req1_b = '0;
    logic [2:0]       in_req0_op = '0, in_req1_op = '0;
    logic [WIDTH-1:0] out_alu_a, out_alu_b;
    logic [2:0]       out_alu_op;
    logic [WIDTH-1:0] in_alu_result;
    logic             in_alu_zero, in_alu_neg;
    logic             out_resp_valid;
    logic             in_resp_ready = 1'b1;
    logic             out_resp_id;
    logic [WIDTH-1:0] out_resp_result;
    logic             out_resp_zero, out_resp_neg, out_flag_zero, out_flag_neg, out_busy;

    logic ovr = 1'b0, ovr_zero = 1'b0, ovr_neg = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
        logic             fzero;
        logic             fneg;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.WIDTH(WIDTH), .NOP_OP(3'b011)) dut (
        .clk(clk), .rst(rst),
        .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
        .in_req0_a(in_req0_a), .in_req0_b(in_req0_b), .in_req0_op(in_req0_op),
        .in_req1_a(in_req1_a), .in_req1_b(in_req1_b), .in_req1_op(in_req1_op),
        .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_op(out_alu_op),
        .in_alu_result(in_alu_result), .in_alu_zero(in_alu_zero), .in_alu_neg(in_alu_neg),
        .out_resp_valid(out_resp_valid), .in_resp_ready(in_resp_ready),
        .out_resp_id(out_resp_id), .out_resp_result(out_resp_result),
        .out_resp_zero(out_resp_zero), .out_resp_neg(out_resp_neg),
        .out_flag_zero(out_flag_zero), .out_flag_neg(out_flag_neg), .out_busy(out_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU; undefined opcodes return junk so NOP handling is visible.
    always_comb begin
        case (out_alu_op)
            3'b100:  in_alu_result = out_alu_a + out_alu_b;
            3'b010:  in_alu_result = out_alu_a + 1;
            3'b001:  in_alu_result = '0 - out_alu_a;
            3'b000:  in_alu_result = out_alu_b - out_alu_a;
            3'b111:  in_alu_result = out_alu_a;
            default: in_alu_result = 32'hDEAD_BEEF;
        endcase
        in_alu_zero = (in_alu_result == '0);
        in_alu_neg  = in_alu_result[WIDTH-1];
        if (ovr) begin
            in_alu_zero = ovr_zero;
            in_alu_neg  = ovr_neg;
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_resp_valid && in_resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(out_resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_id", 32'(out_resp_id), 32'(e.id));
                check("resp_result", out_resp_result, e.result);
                check("resp_zero", 32'(out_resp_zero), 32'(e.zero));
                check("resp_neg", 32'(out_resp_neg), 32'(e.neg));
                check("flag_zero", 32'(out_flag_zero), 32'(e.fzero));
                check("flag_neg", 32'(out_flag_neg), 32'(e.fneg));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input logic push, input logic [WIDTH-1:0] r,
                         input logic z, input logic n, input logic fz, input logic fn);
        bit got = 0;
        if (id) begin in_req1_a = a; in_req1_b = b; in_req1_op = op; end
        else    begin in_req0_a = a; in_req0_b = b; in_req0_op = op; end
        in_req_valid[id] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = out_req_ready[id];
        end
        check("grant_seen", 32'(got), 32'd1);
        check("ready_onehot", 32'(out_req_ready), 32'(id ? 2'b10 : 2'b01));
        if (push) sb.push_back('{id, r, z, n, fz, fn});
        @(posedge clk); #1;
        in_req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !out_busy;
        end
        check("drain", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ready", 32'(out_req_ready), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_resp_valid", 32'(out_resp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        bit got;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_alu_op", 32'(out_alu_op), 32'(3'b011));
        check("rst_alu_a", out_alu_a, 32'd0);
        check("rst_resp_result", out_resp_result, 32'd0);
        check("rst_flags", 32'({out_flag_zero, out_flag_neg}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: add 5+7, latency and registered operands
        issue(1'b0, 32'd5, 32'd7, 3'b100, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_busy", 32'(out_busy), 32'd1);
        check("t1_valid_early", 32'(out_resp_valid), 32'd0);
        check("t1_alu_ab", {out_alu_a[15:0], out_alu_b[15:0]}, {16'd5, 16'd7});
        check("t1_alu_op", 32'(out_alu_op), 32'(3'b100));
        @(negedge clk);
        check("t1_valid", 32'(out_resp_valid), 32'd1);
        drain();

        // 2: both valid continuously -> 0,1,0,1 every 3 cycles
        do_reset();
        in_req0_a = 32'd1; in_req0_b = 32'd0; in_req0_op = 3'b010;
        in_req1_a = 32'd3; in_req1_b = 32'd3; in_req1_op = 3'b000;
        in_req_valid = 2'b11;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = |out_req_ready;
            end
            check("t2_ready", 32'(out_req_ready), (g % 2) ? 32'd2 : 32'd1);
            if (g > 0) check("t2_interval", 32'(cyc - last), 32'd3);
            last = cyc;
            if (g % 2) sb.push_back('{1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0});
            else       sb.push_back('{1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0});
            @(posedge clk);
        end
        #1 in_req_valid = 2'b00;
        drain();

        // 3: NOP-class ops report sticky flags, leave them alone
        issue(1'b1, 32'd9, 32'd4, 3'b011, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        issue(1'b1, 32'd9, 32'd4, 3'b101, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_alu_op", 32'(out_alu_op), 32'(3'b011));
        check("t3_alu_a", out_alu_a, 32'd9);
        drain();

        // 4: backpressure on wrap-around add
        in_resp_ready = 1'b0;
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        in_req_valid = 2'b11;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = out_resp_valid;
        end
        check("t4_valid_seen", 32'(got), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_resp_valid), 32'd1);
            check("t4_hold_result", out_resp_result, 32'd0);
            check("t4_hold_zero", 32'(out_resp_zero), 32'd1);
            check("t4_req_ready", 32'(out_req_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_req_valid = 2'b00;
        in_resp_ready = 1'b1;
        drain();

        // 5: reset during EXEC of a req1 op drops it and re-arms pointer
        issue(1'b1, 32'd2, 32'd3, 3'b100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(out_busy), 32'd0);
        check("t5_resp", 32'({out_resp_valid, out_resp_id, out_resp_zero, out_resp_neg}), 32'd0);
        check("t5_result", out_resp_result, 32'd0);
        check("t5_alu", {out_alu_a[27:0], 1'b0, out_alu_op}, {28'd0, 4'b0011});
        check("t5_alu_b", out_alu_b, 32'd0);
        check("t5_flags", 32'({out_flag_zero, out_flag_neg}), 32'd0);
        @(posedge clk); #1;
        in_req1_op = 3'b111;
        in_req_valid[1] = 1'b1;
        issue(1'b0, 32'h8000_0000, 32'd0, 3'b111, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        in_req_valid = 2'b00;
        drain();

        // 6: negate; flags come straight from the ALU flag inputs
        issue(1'b1, 32'd1, 32'd0, 3'b001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();
        ovr = 1'b1; ovr_zero = 1'b1; ovr_neg = 1'b0;
        issue(1'b0, 32'd1, 32'd0, 3'b001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        ovr = 1'b0;

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the datapath execute stage and requester 1 is the branch/PC unit.
- Each requester issues one operation through a valid/ready handshake.
- The block picks a requester round-robin, drives the ALU operand and opcode lines from registers, captures the result, and returns it with flags on a response handshake.
- It also keeps the architectural sticky zero/neg flags seen by branch logic.

Parameters:
- WIDTH, 32, operand/result width.
- NOP_OP, 3'b011, ALU opcode that leaves the flags unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_req_valid  in  2  per-requester request valid (bit0 = req0, bit1 = req1).
- out_req_ready  out  2  per-requester accept; at most one bit high.
- in_req0_a, in_req0_b  in  WIDTH each  req0 operands.
- in_req0_op  in  3  req0 opcode.
- in_req1_a, in_req1_b  in  WIDTH each  req1 operands.
- in_req1_op  in  3  req1 opcode.
- out_alu_a, out_alu_b  out  WIDTH each  registered ALU operands.
- out_alu_op  out  3  registered ALU opcode.
- in_alu_result  in  WIDTH  ALU result.
- in_alu_zero  in  1  ALU zero flag.
- in_alu_neg  in  1  ALU neg flag.
- out_resp_valid  out  1  response valid.
- in_resp_ready  in  1  response accept.
- out_resp_id  out  1  requester that owns the response.
- out_resp_result  out  WIDTH  captured result.
- out_resp_zero, out_resp_neg  out  1 each  flags for this op.
- out_flag_zero, out_flag_neg  out  1 each  sticky architectural flags.
- out_busy  out  1  high whenever state != IDLE.

Behaviour:
- Legal ALU ops: 100 add, 010 inc, 001 neg, 000 sub (b-a), 111 pass.
- Any other op (011, 101, 110) is a NOP-class op.
- States: IDLE, EXEC, RESP. FSM state and priority pointer encoding is free; only port behaviour is specified.
- Reset (sync, rst=1 at an edge) sets:
  - state to IDLE and priority pointer to 0;
  - out_req_ready=0, out_resp_valid=0, out_resp_id=0;
  - out_resp_result=0, out_resp_zero=0, out_resp_neg=0;
  - out_alu_a=0, out_alu_b=0, out_alu_op=NOP_OP;
  - out_flag_zero=0, out_flag_neg=0, out_busy=0.
- Reset mid-operation discards the in-flight op; no response is produced.
- IDLE:
  - out_req_ready is combinational: grant the pointer requester if valid, else the other requester if valid, else none.
  - Accept = valid & ready for the granted bit.
  - On accept: latch a/b/op into out_alu_*. NOP-class ops drive out_alu_op=NOP_OP with a/b still latched.
  - On accept: record the id, flip the pointer to the non-granted requester, go to EXEC.
- EXEC (exactly 1 cycle):
  - out_req_ready=0.
  - At the edge, capture in_alu_result/zero/neg into the response registers.
  - For NOP-class ops, capture result 0 and take the response flags from the current sticky flags.
  - For legal ops, update the sticky flags with the ALU flags at the same edge. NOP-class ops leave them unchanged.
  - Go to RESP.
- RESP:
  - out_resp_valid=1; response fields stay stable until in_resp_ready=1.
  - On the handshake edge go to IDLE; the next accept is possible the following cycle.
- Latency:
  - Accept at edge N, out_resp_valid high after edge N+1.
  - Minimum issue interval is 3 cycles with in_resp_ready held high.
- Fairness: with both requesters continuously valid, grants strictly alternate. No requester waits more than one other op.
- Requester bits not granted see ready=0 and must hold their request stable.
- out_alu_* hold their values outside IDLE accepts.
- Arithmetic is wrap-around at WIDTH; the block performs no arithmetic itself.

Test Plan:
1. Reset, then req0 valid with a=5, b=7, op=100 -> ready0=1 in that cycle; resp_valid after 2 edges with id=0, result=12, zero=0; flag_zero=0.
2. req0 and req1 both valid continuously, ops a=1/op=010 and a=3,b=3/op=000 -> grants alternate 0,1,0,1; req1 responses give result=0, zero=1, flag_zero=1.
3. Sticky-flag NOP: after the sub 3-3 (flag_zero=1), req1 issues op=011 -> result=0, resp_zero=1, flags unchanged. Then op=101 -> same, out_alu_op=011.
4. Backpressure: in_resp_ready=0 for 4 cycles after add 0xFFFFFFFF+1 -> result=0, zero=1 held stable 4 cycles; req ready stays 0; completes on ready=1.
5. Reset asserted during EXEC of req1 op -> next cycle all outputs at reset values; no response; priority pointer back to 0 (simultaneous valids grant req0).
6. Negate a=1 op=001 -> result 0xFFFFFFFF; response and sticky flags mirror in_alu_zero/in_alu_neg values driven by the bench.
